// File: rtl/result_drain_ctrl_pkg.sv
// result_drain_ctrl_pkg
//   Shared constants and types for the result drain path (and the load FSM
//   that reuses the index counter).
//   DRAIN_N        : default PE array dimension (N x N result RAMs)
//   DRAIN_C        : default ram_c address width
//   DRAIN_DW       : result word width, fixed fp32
//   BYTES_PER_WORD : UART bytes per result word
//   drain_state_t  : drain FSM states
package result_drain_ctrl_pkg;

  localparam int DRAIN_N        = 4;
  localparam int DRAIN_C        = 8;
  localparam int DRAIN_DW       = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    LATCH,
    SEND,
    WAIT_TX,
    ADV,
    FINISH
  } drain_state_t;

endpackage

// File: rtl/result_drain_ctrl_if.sv
// result_drain_ctrl_if
//   Groups the result-RAM read bus and the UART TX handshake used while
//   draining results.
//   ram_c_addr     : per-PE read address (all entries carry the same value)
//   pe_row/pe_col  : select for the result read mux
//   ram_c_rdata    : muxed read data, valid one cycle after address/select
//   uart_tx_data   : byte to transmit
//   uart_send_data : one-cycle request to transmit uart_tx_data
//   uart_tx_done   : one-cycle pulse when the UART has sent the byte
//   master modport : drain controller side; slave modport : RAM/UART side
interface result_drain_ctrl_if
  import result_drain_ctrl_pkg::*;
#(
  parameter int N  = DRAIN_N,
  parameter int C  = DRAIN_C,
  parameter int DW = DRAIN_DW
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*N-1:0][C-1:0] ram_c_addr;
  logic [SEL_W-1:0]      pe_row;
  logic [SEL_W-1:0]      pe_col;
  logic [DW-1:0]         ram_c_rdata;
  logic [7:0]            uart_tx_data;
  logic                  uart_send_data;
  logic                  uart_tx_done;

  modport master (
    output ram_c_addr,
    output pe_row,
    output pe_col,
    input  ram_c_rdata,
    output uart_tx_data,
    output uart_send_data,
    input  uart_tx_done
  );

  modport slave (
    input  ram_c_addr,
    input  pe_row,
    input  pe_col,
    output ram_c_rdata,
    input  uart_tx_data,
    input  uart_send_data,
    output uart_tx_done
  );

endinterface

// File: rtl/result_drain_ctrl_drain_index_counter.sv
// drain_index_counter
//   Nested row / col / addr counter walking N x N PEs, seg_length words each,
//   row outermost and addr innermost.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : zero all three counters
//   advance    : step to the next (row, col, addr) position
//   seg_length : words per PE (must be >= 1 while advancing)
//   row, col   : current PE coordinates
//   addr       : current word address within the PE
//   last       : current position is the final word of the traversal
module drain_index_counter
  import result_drain_ctrl_pkg::*;
#(
  parameter int N = DRAIN_N,
  parameter int C = DRAIN_C
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 advance,
  input  logic [C-1:0]                         seg_length,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] row,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] col,
  output logic [C-1:0]                         addr,
  output logic                                 last
);

  localparam int               SEL_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

  logic addr_wrap;
  logic col_wrap;
  logic row_last;

  assign addr_wrap = (addr == (seg_length - C'(1)));
  assign col_wrap  = (col == LAST_SEL);
  assign row_last  = (row == LAST_SEL);
  assign last      = addr_wrap && col_wrap && row_last;

  // Odometer-style update: addr rolls into col, col rolls into row. After
  // the final word everything wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (addr_wrap) begin
        addr <= '0;
        if (col_wrap) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl
//   Reads every word of the N x N PE result RAMs after a computation and
//   sends each 32-bit result to the UART as four bytes, MSB first.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle pulse that begins a drain (ignored while busy)
//   seg_length : words per PE RAM, latched on the accepted start
//   busy       : high while the FSM is out of IDLE
//   drain_done : one-cycle pulse after the last byte completes
//   bus        : result-RAM read bus and UART TX handshake (master side)
module result_drain_ctrl
  import result_drain_ctrl_pkg::*;
#(
  parameter int N  = DRAIN_N,
  parameter int C  = DRAIN_C,
  parameter int DW = DRAIN_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             seg_length,
  output logic                   busy,
  output logic                   drain_done,
  result_drain_ctrl_if.master    bus
);

  localparam int         SEL_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  drain_state_t     state_q;
  drain_state_t     state_d;
  logic [C-1:0]     seg_len_q;
  logic [DW-1:0]    shreg_q;
  logic [1:0]       byte_idx_q;
  logic             drain_done_q;
  logic             cnt_clear;
  logic             cnt_advance;
  logic             cnt_last;
  logic [SEL_W-1:0] cnt_row;
  logic [SEL_W-1:0] cnt_col;
  logic [C-1:0]     cnt_addr;

  drain_index_counter #(
    .N (N),
    .C (C)
  ) u_index (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .seg_length (seg_len_q),
    .row        (cnt_row),
    .col        (cnt_col),
    .addr       (cnt_addr),
    .last       (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter control. A zero-length drain skips straight to
  // FINISH without touching the counters, so the read address stays put.
  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (seg_length == 8'd0) begin
            state_d = FINISH;
          end else begin
            cnt_clear = 1'b1;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_d = LATCH;
      LATCH:   state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.uart_tx_done) begin
          state_d = (byte_idx_q == LAST_BYTE) ? ADV : SEND;
        end
      end
      ADV: begin
        cnt_advance = 1'b1;
        state_d     = cnt_last ? FINISH : RD_WAIT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte shifter: load the word once the RAM data is valid, then move the
  // next byte into the top slot each time the UART reports a byte sent.
  // The byte index wraps naturally from 3 back to 0 at the end of a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_len_q    <= '0;
      shreg_q      <= '0;
      byte_idx_q   <= '0;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= (state_q == FINISH);
      if ((state_q == IDLE) && start) begin
        seg_len_q  <= C'(seg_length);
        byte_idx_q <= '0;
      end
      if (state_q == LATCH) begin
        shreg_q <= bus.ram_c_rdata;
      end
      if ((state_q == WAIT_TX) && bus.uart_tx_done) begin
        shreg_q    <= {shreg_q[DW-9:0], 8'h00};
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

  assign busy               = (state_q != IDLE);
  assign drain_done         = drain_done_q;
  assign bus.uart_send_data = (state_q == SEND);
  assign bus.uart_tx_data   = shreg_q[DW-1 -: 8];
  assign bus.ram_c_addr     = {(N*N){cnt_addr}};
  assign bus.pe_row         = cnt_row;
  assign bus.pe_col         = cnt_col;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// tb_result_drain_ctrl
//   Randomised scoreboard bench for result_drain_ctrl with N=2. Stimulus
//   fills a RAM model, pushes the expected byte stream and then starts a
//   drain; a monitor pops and compares on every send / drain_done, and a
//   UART responder answers each send with tx_done after a set delay.
module tb_result_drain_ctrl;
  import result_drain_ctrl_pkg::*;

  localparam int TN = 2;
  localparam int TC = 8;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    int         row;
    int         col;
    int         addr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seg_length;
  logic       busy;
  logic       drain_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       exp_q[$];
  logic [31:0] mem [TN*TN][256];
  int         rd_pe;

  int         tx_delay    = 5;
  bit         spurious_en = 1'b0;
  bit         tx_done_legit;
  bit         rsp_pending = 1'b0;
  int         rsp_left    = 0;
  logic [7:0] rsp_held    = 8'h00;

  int         mon_cyc       = 0;
  int         mon_ev_cyc    = 0;
  int         mon_gap       = -1;
  int         mon_sends     = 0;
  bit         mon_busy_prev = 1'b0;
  exp_t       mon_it;

  result_drain_ctrl_if #(.N(TN), .C(TC), .DW(32)) bus_if ();

  result_drain_ctrl #(
    .N  (TN),
    .C  (TC),
    .DW (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seg_length (seg_length),
    .busy       (busy),
    .drain_done (drain_done),
    .bus        (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model behind the row/col mux.
  always_comb rd_pe = int'(bus_if.pe_row) * TN + int'(bus_if.pe_col);
  always @(posedge clk) bus_if.ram_c_rdata <= mem[rd_pe][bus_if.ram_c_addr[rd_pe]];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < TN*TN; i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(bus_if.ram_c_addr[i]), 32'd0);
    checkOutput({tag, "_pe_row"}, 32'(bus_if.pe_row), 32'd0);
    checkOutput({tag, "_pe_col"}, 32'(bus_if.pe_col), 32'd0);
    checkOutput({tag, "_tx_data"}, 32'(bus_if.uart_tx_data), 32'd0);
    checkOutput({tag, "_send"}, 32'(bus_if.uart_send_data), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_drain_done"}, 32'(drain_done), 32'd0);
  endtask

  function automatic logic [31:0] wordFor(input int mode, input int r, input int c, input int a);
    case (mode)
      0:       return 32'h3F80_0000;
      1:       return {8'(r), 8'(c), 8'(a), 8'h5A ^ 8'(a)};
      default: return $urandom();
    endcase
  endfunction

  // Fill the RAMs, queue the expected bytes in PE-major order, pulse start.
  task automatic applyStimulus(input int seg, input int mode);
    exp_t        it;
    logic [31:0] w;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++)
        for (int a = 0; a < seg; a++) begin
          w = wordFor(mode, r, c, a);
          mem[r*TN + c][a] = w;
          for (int b = 0; b < 4; b++) begin
            it.is_done = 1'b0;
            it.data    = w[31 - 8*b -: 8];
            it.row     = r;
            it.col     = c;
            it.addr    = a;
            exp_q.push_back(it);
          end
        end
    it.is_done = 1'b1;
    it.data    = 8'h00;
    it.row     = 0;
    it.col     = 0;
    it.addr    = 0;
    exp_q.push_back(it);
    @(negedge clk);
    seg_length = 8'(seg);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for drain_done; optionally fire stray starts with new
  // seg_length values while the drain runs.
  task automatic waitDrain(input bit noisy, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (drain_done) begin
        seen = 1'b1;
      end else if (noisy && $urandom_range(0, 4) == 0) begin
        start      = 1'b1;
        seg_length = 8'($urandom_range(0, 255));
      end
    end
    start = 1'b0;
    checkOutput("drain_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("busy_after_drain", 32'(busy), 32'd0);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // UART responder: tx_done a fixed (or random) number of cycles after each
  // send, checking tx_data stays stable meanwhile; optional stray pulses.
  initial begin
    bus_if.uart_tx_done = 1'b0;
    tx_done_legit       = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.uart_tx_done = 1'b0;
      tx_done_legit       = 1'b0;
      if (rst) begin
        rsp_pending = 1'b0;
      end else if (rsp_pending) begin
        checkOutput("tx_data_hold", 32'(bus_if.uart_tx_data), 32'(rsp_held));
        rsp_left--;
        if (rsp_left == 0) begin
          bus_if.uart_tx_done = 1'b1;
          tx_done_legit       = 1'b1;
          rsp_pending         = 1'b0;
        end
      end else if (bus_if.uart_send_data) begin
        rsp_held    = bus_if.uart_tx_data;
        rsp_pending = 1'b1;
        rsp_left    = (tx_delay > 0) ? tx_delay : int'($urandom_range(1, 6));
        if (spurious_en) bus_if.uart_tx_done = 1'b1;
      end else if (spurious_en && $urandom_range(0, 3) == 0) begin
        bus_if.uart_tx_done = 1'b1;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge. Tracks the cycle of
  // the event that should trigger the next send (start: 3, tx_done inside a
  // word: 1, last tx_done of a word: 4) and scores every send / drain_done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (rst) begin
        exp_q.delete();
        mon_gap       = -1;
        mon_sends     = 0;
        mon_busy_prev = 1'b0;
      end else begin
        if (start && !mon_busy_prev) begin
          mon_ev_cyc = mon_cyc - 1;
          mon_gap    = (seg_length != 8'd0) ? 3 : -1;
          mon_sends  = 0;
        end
        if (bus_if.uart_tx_done && tx_done_legit) begin
          mon_ev_cyc = mon_cyc - 1;
          mon_gap    = (mon_sends % 4 == 0) ? 4 : 1;
        end
        if (bus_if.uart_send_data) begin
          mon_sends++;
          checkOutput("send_latency", 32'(mon_cyc - mon_ev_cyc), 32'(mon_gap));
          mon_gap = -1;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_send", 32'(bus_if.uart_send_data), 32'd0);
          end else begin
            mon_it = exp_q.pop_front();
            checkOutput("send_not_done_slot", 32'(mon_it.is_done), 32'd0);
            checkOutput("tx_byte", 32'(bus_if.uart_tx_data), 32'(mon_it.data));
            checkOutput("pe_row", 32'(bus_if.pe_row), 32'(mon_it.row));
            checkOutput("pe_col", 32'(bus_if.pe_col), 32'(mon_it.col));
            for (int i = 0; i < TN*TN; i++)
              checkOutput($sformatf("ram_c_addr%0d", i), 32'(bus_if.ram_c_addr[i]), 32'(mon_it.addr));
          end
        end
        if (drain_done) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_drain_done", 32'(drain_done), 32'd0);
          end else begin
            mon_it = exp_q.pop_front();
            checkOutput("drain_done_slot", 32'(mon_it.is_done), 32'd1);
          end
        end
        mon_busy_prev = busy;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 900000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sends;
    int dones;
    int seg;
    rst        = 1'b1;
    start      = 1'b0;
    seg_length = 8'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] constant 0x3F800000, seg_length=1");
    tx_delay = 5;
    applyStimulus(1, 0);
    waitDrain(1'b0, 2000);

    $display("[TB] encoded words, seg_length=3");
    tx_delay = 2;
    applyStimulus(3, 1);
    waitDrain(1'b0, 3000);

    $display("[TB] seg_length=0");
    applyStimulus(0, 0);
    checkOutput("seg0_busy_c1", 32'(busy), 32'd1);
    checkOutput("seg0_done_c1", 32'(drain_done), 32'd0);
    @(negedge clk);
    checkOutput("seg0_busy_c2", 32'(busy), 32'd0);
    checkOutput("seg0_done_c2", 32'(drain_done), 32'd1);
    @(negedge clk);
    checkOutput("seg0_done_c3", 32'(drain_done), 32'd0);
    checkOutput("seg0_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] stray tx_done and start pulses during drain");
    tx_delay    = 4;
    spurious_en = 1'b1;
    applyStimulus(3, 2);
    waitDrain(1'b1, 4000);
    spurious_en = 1'b0;

    $display("[TB] reset during byte 2 of word 5");
    tx_delay = 3;
    applyStimulus(3, 1);
    sends = 0;
    for (int i = 0; i < 2000 && sends < 23; i++) begin
      @(negedge clk);
      if (bus_if.uart_send_data) sends++;
    end
    checkOutput("reset_point_reached", 32'(sends), 32'd23);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drain_done) dones++;
    end
    checkOutput("no_done_after_reset", 32'(dones), 32'd0);
    applyStimulus(2, 1);
    waitDrain(1'b0, 3000);

    $display("[TB] random runs");
    for (int t = 0; t < 3; t++) begin
      seg         = int'($urandom_range(1, 4));
      tx_delay    = 0;
      spurious_en = 1'($urandom_range(0, 1));
      applyStimulus(seg, 2);
      waitDrain(1'($urandom_range(0, 1)), 4 * TN * TN * seg * 14 + 100);
    end
    spurious_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
